// File: rtl/uart_tx.sv
// uart_tx: serialises one accepted byte as start, LSB-first data, optional parity and stop bits.
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [DATA_BITS-1:0] TX_data,
  input  logic                 TX_valid,
  output logic                 TX_ready,
  output logic                 TX_out,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [BW-1:0] idx, idx_nx;
  logic [DATA_BITS-1:0] sh, sh_nx;
  logic par, par_nx, tx_nx, done_nx, tick, last, accept;
  assign tick     = cnt == CW'(CLKS_PER_BIT - 1);
  assign last     = idx == BW'(DATA_BITS - 1);
  assign accept   = TX_valid && state == IDLE;
  assign TX_ready = state == IDLE;
  assign busy     = state != IDLE;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      cnt    <= '0;
      idx    <= '0;
      sh     <= '0;
      par    <= 1'b0;
      TX_out <= 1'b1;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      idx    <= idx_nx;
      sh     <= sh_nx;
      par    <= par_nx;
      TX_out <= tx_nx;
      done   <= done_nx;
    end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (TX_valid) state_nx = START;
      START:   if (tick) state_nx = DATA;
      DATA:    if (tick && last) state_nx = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (tick) state_nx = STOP;
      STOP:    if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // Line value is registered from the next-cycle state so TX_out has no comb path.
  always_comb begin
    cnt_nx  = (state == IDLE || tick) ? '0 : cnt + CW'(1);
    idx_nx  = (state != DATA || (tick && last)) ? '0 : tick ? idx + BW'(1) : idx;
    sh_nx   = accept ? TX_data : (state == DATA && tick) ? sh >> 1 : sh;
    par_nx  = accept ? (^TX_data) ^ (PARITY_ODD != 0) : par;
    tx_nx   = state_nx == START ? 1'b0 : state_nx == DATA ? sh_nx[0] :
              state_nx == PARITY ? par : 1'b1;
    done_nx = state == STOP && tick;
  end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmit engine, the TX counterpart of the receive SIPO path. It accepts one parallel byte through a valid/ready handshake and serialises it onto TX_out as a frame: start bit, DATA_BITS data bits LSB-first, an optional parity bit and one stop bit. Each bit is held for CLKS_PER_BIT system clocks. It sits between the host-side byte interface and the UART pin.

Parameters:
CLKS_PER_BIT, 16, system clocks per serial bit (>=2)
DATA_BITS, 8, payload width (5..9)
PARITY_EN, 1, 1 = parity bit inserted after the data bits, 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous active-low reset
TX_data  input  DATA_BITS  byte to send; sampled only at acceptance
TX_valid  input  1  host has a byte on TX_data
TX_ready  output  1  block can accept a byte (high only in IDLE)
TX_out  output  1  serial line, registered, idles high
busy  output  1  high from acceptance until the frame completes
done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, TX_out=1, TX_ready=1, busy=0, done=0, bit counter=0, clock counter=0. Reset applied mid-frame aborts the frame immediately. The line returns high with no stop bit. After release the block is in IDLE.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- Acceptance: a byte is accepted on a rising edge where TX_valid=1 and TX_ready=1. At that edge:
  - TX_data is latched into the shift register.
  - Parity is computed from the latched data: XOR of the data bits, inverted if PARITY_ODD.
  - State goes to START, TX_ready=0, busy=1.
- TX_data and TX_valid are ignored outside IDLE.
- Latency: TX_out goes low in the first cycle after the acceptance edge.
- Bit timing: every bit (start, each data bit, parity, stop) drives TX_out for exactly CLKS_PER_BIT consecutive cycles. The clock counter runs 0..CLKS_PER_BIT-1. The bit advances when the counter reaches CLKS_PER_BIT-1, and the counter then wraps to 0.
- DATA state: the bit index runs 0..DATA_BITS-1 with LSB first. The shift register shifts right once per bit period. After bit DATA_BITS-1, go to PARITY (or to STOP if PARITY_EN=0).
- STOP: TX_out=1 for CLKS_PER_BIT cycles. Then:
  - state=IDLE, TX_ready=1, busy=0.
  - done=1 for that single first IDLE cycle only.
- Frame length: (2+DATA_BITS+PARITY_EN)*CLKS_PER_BIT cycles of TX_out activity.
- Back-to-back: if TX_valid is held high, the next byte is accepted at the end of the first IDLE cycle, the same cycle done is high. Between frames the line is high for CLKS_PER_BIT (stop bit) + 1 cycles.
- TX_valid asserted during a frame is not an error. It is held pending by the host and accepted when TX_ready rises.
- Counter widths: the clock counter is $clog2(CLKS_PER_BIT) bits and the bit counter is $clog2(DATA_BITS) bits. Neither counter may exceed its terminal count.

Test Plan:
1. Reset: assert RST_N=0 mid-cycle -> TX_out=1, TX_ready=1, busy=0, done=0 immediately, without waiting for a clock edge.
2. CLKS_PER_BIT=4, even parity, TX_data=0xA5 -> each of the following bits held 4 cycles:
   - start bit 0,
   - data bits 1,0,1,0,0,1,0,1,
   - parity bit 0,
   - stop bit 1.
   The frame totals 44 cycles; done pulses once, then TX_ready=1.
3. PARITY_ODD=1, TX_data=0x01 -> parity bit 0. With TX_data=0x03 -> parity bit 1. With PARITY_EN=0 -> frame is 40 cycles and the parity slot is absent.
4. TX_valid held high with 0x55 then 0xFF -> two complete frames with TX_out high for exactly 5 cycles between them (4 stop + 1 idle), and done pulses twice.
5. TX_data changed mid-frame from 0xA5 to 0x00 -> transmitted bits still match 0xA5.
6. RST_N pulsed low during data bit 3 -> TX_out=1 at once, no done pulse. After release a new 0x3C frame transmits correctly.
